// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the cache/main-memory bus arbiter.
// States are plain constants so the encoding stays visible in legacy dumps.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W_DEF       = 28;
  localparam int BLOCK_W_DEF      = 128;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SERVE_I = 3'd1;
  localparam logic [2:0] ST_SERVE_D = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_QUIESCE = 3'd4;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_priority_select.sv
// Dcache-first grant selection, with a saturating counter that hands the bus
// to the icache once the dcache has won STARVE_LIMIT grants in a row.
module arb_priority_select
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   pick_en,
  input  logic   i_req,
  input  logic   d_req,
  output owner_t grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant = OWNER_NONE;
    if (pick_en) begin
      if (d_req && !starved)  grant = OWNER_D;
      else if (i_req)         grant = OWNER_I;
      else if (d_req)         grant = OWNER_D;
    end
  end

  // Counts only dcache wins taken while the icache was left waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant == OWNER_I) begin
      starve_cnt <= '0;
    end else if (grant == OWNER_D) begin
      if (!i_req)        starve_cnt <= '0;
      else if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single main-memory block port between icache and dcache,
// with a quiesce handshake that freezes the bus for cache-context switches.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int BLOCK_W      = BLOCK_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_address,
  output logic [BLOCK_W-1:0] i_readdata,
  output logic               i_ready,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_address,
  input  logic [BLOCK_W-1:0] d_writedata,
  output logic [BLOCK_W-1:0] d_readdata,
  output logic               d_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_ready,
  input  logic               switch_req,
  output logic               switch_ack
);

  state_t state;
  owner_t grant;
  logic   d_req;
  logic   pick_en;

  assign d_req   = d_read | d_write;
  assign pick_en = (state == ST_IDLE) && !switch_req;

  arb_priority_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk     (clk),
    .reset   (reset),
    .pick_en (pick_en),
    .i_req   (i_read),
    .d_req   (d_req),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      i_readdata    <= '0;
      i_ready       <= 1'b0;
      d_readdata    <= '0;
      d_ready       <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      switch_ack    <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (switch_req) begin
            state      <= ST_QUIESCE;
            switch_ack <= 1'b1;
          end else if (grant == OWNER_D) begin
            // A write-back wins over a simultaneous read from the same cache.
            state         <= ST_SERVE_D;
            mem_write     <= d_write;
            mem_read      <= !d_write;
            mem_address   <= d_address;
            mem_writedata <= d_writedata;
          end else if (grant == OWNER_I) begin
            state         <= ST_SERVE_I;
            mem_read      <= 1'b1;
            mem_address   <= i_address;
            mem_writedata <= '0;
          end
        end
        ST_SERVE_I: begin
          if (mem_ready) begin
            mem_read   <= 1'b0;
            i_readdata <= mem_readdata;
            i_ready    <= 1'b1;
            state      <= ST_RELEASE;
          end
        end
        ST_SERVE_D: begin
          if (mem_ready) begin
            if (mem_read) d_readdata <= mem_readdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            d_ready   <= 1'b1;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (switch_req) begin
            state      <= ST_QUIESCE;
            switch_ack <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_QUIESCE: begin
          if (!switch_req) begin
            state      <= ST_IDLE;
            switch_ack <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          switch_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
